div_arbiter: RTL and testbench

- Shares one 32-bit unsigned restoring divider (start-pulse / finish-level interface, 33-bit quotient, 32-bit remainder) between N_REQ requesters.
- Grants requests round-robin, latches operands, and sequences the divider's start pulse.
- Waits for the divider's finish, then returns quotient/remainder to the granted requester over a valid/ready response channel.
- Sits between the execute-stage requesters (e.g. integer pipe, address unit) and the single divider instance.

---
 rtl/div_arbiter_pkg.sv | 13 +
 rtl/div_arbiter_rr_grant.sv | 26 ++
 rtl/div_arbiter.sv | 106 ++++++++++
 tb/tb_div_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: shared constants for the round-robin divider arbiter
// Holds the FSM state encoding, the divide-by-zero quotient and the
// default requester count / index width used by div_arbiter and its picker.
package div_arbiter_pkg;
    localparam int DIV_ARB_N_REQ = 4;
    localparam int DIV_ARB_ID_W  = 2;
    localparam logic [2:0] DIV_ARB_IDLE     = 3'd0;
    localparam logic [2:0] DIV_ARB_START    = 3'd1;
    localparam logic [2:0] DIV_ARB_WAIT_CLR = 3'd2;
    localparam logic [2:0] DIV_ARB_BUSY     = 3'd3;
    localparam logic [2:0] DIV_ARB_RESP     = 3'd4;
    localparam logic [32:0] DIV_ARB_ZERO_QUO = 33'h1_FFFF_FFFF;
endpackage

// File: rtl/div_arbiter_rr_grant.sv
// div_arbiter_rr_grant: combinational round-robin priority picker
// Ports:
//   req      in  N_REQ  request vector
//   rrPtr    in  ID_W   index with highest priority this cycle
//   grant    out N_REQ  one-hot grant (zero when nothing requests)
//   grantId  out ID_W   encoded index of the granted requester
//   anyValid out 1      at least one request present
module div_arbiter_rr_grant import div_arbiter_pkg::*; #(
    parameter int N_REQ = DIV_ARB_N_REQ,
    parameter int ID_W  = DIV_ARB_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rrPtr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grantId,
    output logic             anyValid
);
    // Scan from the farthest offset back to rrPtr so the closest requester wins.
    always_comb begin
        grantId  = '0;
        anyValid = |req;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(rrPtr) + k) % N_REQ]) grantId = ID_W'((int'(rrPtr) + k) % N_REQ);
        grant = anyValid ? N_REQ'(1) << grantId : '0;
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one restoring divider among N_REQ requesters
// Build option: DIV_ARBITER_ZERO_BYPASS_EN answers zero divisors locally
// (quotient all ones, remainder = dividend) without starting the divider.
// Ports:
//   clk, rst              clock / asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or zero)
//   req_a/req_b           packed 32-bit dividends/divisors, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready   per-requester response handshake (valid one-hot)
//   rsp_quo/rsp_rem/rsp_id  result and index of the responding requester
//   div_start             one-cycle start pulse to the divider
//   div_a/div_b           operands held for the whole divide
//   div_quo/div_rem/div_finish  divider result and finish level
module div_arbiter import div_arbiter_pkg::*; #(
    parameter int N_REQ = DIV_ARB_N_REQ,
    parameter int ID_W  = DIV_ARB_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]  rsp_valid,
    input  logic [N_REQ-1:0]  rsp_ready,
    output logic [32:0]       rsp_quo,
    output logic [31:0]       rsp_rem,
    output logic [ID_W-1:0]   rsp_id,
    output logic              div_start,
    output logic [31:0]       div_a,
    output logic [31:0]       div_b,
    input  logic [32:0]       div_quo,
    input  logic [31:0]       div_rem,
    input  logic              div_finish
);
    logic [2:0]       state;
    logic [ID_W-1:0]  rrPtr;
    logic [ID_W-1:0]  grantId;
    logic [ID_W-1:0]  pickId;
    logic [N_REQ-1:0] pick;
    logic             anyValid;
    logic [31:0]      selA;
    logic [31:0]      selB;

    div_arbiter_rr_grant #(.N_REQ(N_REQ), .ID_W(ID_W)) picker (
        .req(req_valid),
        .rrPtr(rrPtr),
        .grant(pick),
        .grantId(pickId),
        .anyValid(anyValid)
    );

    assign selA      = req_a[32*pickId +: 32];
    assign selB      = req_b[32*pickId +: 32];
    assign req_ready = (state == DIV_ARB_IDLE) ? pick : '0;
    assign div_start = state == DIV_ARB_START;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_ARB_IDLE;
            rrPtr     <= '0;
            grantId   <= '0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= '0;
            rsp_quo   <= '0;
            rsp_rem   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                DIV_ARB_IDLE: if (anyValid) begin
                    div_a   <= selA;
                    div_b   <= selB;
                    grantId <= pickId;
                    rrPtr   <= (pickId == ID_W'(N_REQ - 1)) ? '0 : pickId + 1'b1;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
                    if (selB == '0) begin
                        rsp_quo   <= DIV_ARB_ZERO_QUO;
                        rsp_rem   <= selA;
                        rsp_valid <= pick;
                        rsp_id    <= pickId;
                        state     <= DIV_ARB_RESP;
                    end else
                        state <= DIV_ARB_START;
`else
                    state <= DIV_ARB_START;
`endif
                end
                DIV_ARB_START: state <= DIV_ARB_WAIT_CLR;
                // A finish level still high from the previous divide must drop first.
                DIV_ARB_WAIT_CLR: if (!div_finish) state <= DIV_ARB_BUSY;
                DIV_ARB_BUSY: if (div_finish) begin
                    rsp_quo   <= div_quo;
                    rsp_rem   <= div_rem;
                    rsp_valid <= N_REQ'(1) << grantId;
                    rsp_id    <= grantId;
                    state     <= DIV_ARB_RESP;
                end
                DIV_ARB_RESP: if (rsp_ready[grantId]) begin
                    rsp_valid <= '0;
                    state     <= DIV_ARB_IDLE;
                end
                default: state <= DIV_ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed self-checking bench for div_arbiter with a divider model
module tb_div_arbiter;
    localparam int N = 4;
    logic clk = 0;
    logic rst = 0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0] rsp_valid;
    logic [N-1:0] rsp_ready = '0;
    logic [32:0] rsp_quo;
    logic [31:0] rsp_rem;
    logic [1:0] rsp_id;
    logic div_start;
    logic [31:0] div_a, div_b;
    logic [32:0] div_quo = '0;
    logic [31:0] div_rem = '0;
    logic div_finish = 1'b1;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int busy = 0;

    always #5 clk = ~clk;

    div_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_id(rsp_id),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_quo(div_quo), .div_rem(div_rem), .div_finish(div_finish)
    );

    // Divider model: finish stays high one cycle after start, then drops,
    // and rises with the new result a few cycles later.
    always @(posedge clk) begin
        if (div_start) busy <= 6;
        else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 6) div_finish <= 1'b0;
            if (busy == 1) begin
                div_finish <= 1'b1;
                div_quo <= (div_b == 0) ? 33'h1_FFFF_FFFF : {1'b0, div_a / div_b};
                div_rem <= (div_b == 0) ? div_a : div_a % div_b;
            end
        end
    end

    always @(negedge clk) if (rst && div_start) starts++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setReq(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id] = 1'b1;
    endtask

    task automatic serveOne(input int id, input logic [32:0] q, input logic [31:0] r, input bit drop);
        int n = 0;
        #1;
        while (req_ready == 0 && n < 50) begin @(negedge clk); n++; end
        chk("grant", req_ready, 4'b1 << id);
        @(negedge clk);
        if (drop) req_valid[id] = 1'b0;
        n = 0;
        while (rsp_valid == 0 && n < 50) begin @(negedge clk); n++; end
        chk("rsp_valid", rsp_valid, 4'b1 << id);
        chk("rsp_id", rsp_id, id);
        chk("rsp_quo", rsp_quo, q);
        chk("rsp_rem", rsp_rem, r);
        rsp_ready = 4'b1 << id;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    typedef struct {
        int id;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[6];
    int s0;

    initial begin
        vecs[0] = '{0, 32'd100, 32'd7, 33'd14, 32'd2};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'd1, 33'h0_FFFF_FFFF, 32'd0};
        vecs[2] = '{2, 32'd5, 32'd9, 33'd0, 32'd5};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'h1_0000, 33'hFFFF, 32'hFFFF};
        vecs[4] = '{1, 32'd123, 32'd0, 33'h1_FFFF_FFFF, 32'd123};
        vecs[5] = '{0, 32'd1000, 32'd10, 33'd100, 32'd0};

        // Reset state
        #2;
        chk("reset_outputs", {req_ready, rsp_valid, div_start, rsp_id}, 0);
        chk("reset_data", {div_a, div_b, rsp_rem}, 0);
        chk("reset_quo", rsp_quo, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All four at once: grants 0..3 in order
        s0 = starts;
        for (int i = 0; i < N; i++) setReq(i, 32'd1000 + 32'(i), 32'd10);
        for (int i = 0; i < N; i++) serveOne(i, 33'd100, 32'(i), 1'b1);
        chk("all4_starts", starts - s0, 4);

        // Table of single-requester operations
        s0 = starts;
        for (int i = 0; i < 6; i++) begin
            setReq(vecs[i].id, vecs[i].a, vecs[i].b);
            serveOne(vecs[i].id, vecs[i].q, vecs[i].r, 1'b1);
        end
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
        chk("table_starts", starts - s0, 5);
`else
        chk("table_starts", starts - s0, 6);
`endif

        // Last grant was requester 0, so the pointer sits at 1: 2 beats 0
        setReq(0, 32'd40, 32'd3);
        setReq(2, 32'd20, 32'd6);
        serveOne(2, 33'd3, 32'd2, 1'b1);
        serveOne(0, 33'd13, 32'd1, 1'b1);

        // Fairness: 1 and 3 held continuously alternate
        setReq(1, 32'd81, 32'd9);
        setReq(3, 32'd17, 32'd5);
        serveOne(1, 33'd9, 32'd0, 1'b0);
        serveOne(3, 33'd3, 32'd2, 1'b0);
        serveOne(1, 33'd9, 32'd0, 1'b0);
        serveOne(3, 33'd3, 32'd2, 1'b0);
        req_valid = '0;
        @(negedge clk);

        // Response backpressure with a competing request
        setReq(0, 32'd64, 32'd8);
        #1;
        chk("bp_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int n = 0; n < 50 && rsp_valid == 0; n++) @(negedge clk);
        s0 = starts;
        setReq(2, 32'd9, 32'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, req_ready}, {4'b0001, 2'd0, 4'b0000});
            chk("bp_data", {rsp_quo, rsp_rem}, {33'd8, 32'd0});
        end
        rsp_ready = 4'b1010;
        @(negedge clk);
        chk("bp_other_ready_ignored", rsp_valid, 4'b0001);
        chk("bp_no_start", starts - s0, 0);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        serveOne(2, 33'd3, 32'd0, 1'b1);

        // Reset in the middle of a divide
        setReq(0, 32'd77, 32'd7);
        #1;
        chk("mr_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_not_done", rsp_valid, 0);
        #2 rst = 1'b0;
        #1;
        chk("mr_outputs", {req_ready, rsp_valid, div_start, rsp_id}, 0);
        chk("mr_data", {div_a, div_b, rsp_rem}, 0);
        chk("mr_quo", rsp_quo, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s0 = starts;
        setReq(0, 32'd50, 32'd5);
        serveOne(0, 33'd10, 32'd0, 1'b1);
        chk("mr_restart", starts - s0, 1);

`ifdef DIV_ARBITER_ZERO_BYPASS_EN
        // Zero divisor answered locally, one cycle after accept
        s0 = starts;
        setReq(0, 32'd123, 32'd0);
        #1;
        chk("zb_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("zb_valid", rsp_valid, 4'b0001);
        chk("zb_quo", rsp_quo, 33'h1_FFFF_FFFF);
        chk("zb_rem", rsp_rem, 32'd123);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        chk("zb_no_start", starts - s0, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
